// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//   Shares the LC-3 register file between two requesters and sequences each
//   transaction as an optional write (RF_LD held high for WR_HOLD cycles)
//   followed by a dual read. Requester A is execute write-back, requester B
//   is the debug/loader port. Simultaneous requests are settled round-robin,
//   so a waiting requester never waits more than one transaction.
//
//   The register file's SRx outputs are level-sensitive. While RF_LD=0 they
//   follow R[SR1]/R[SR2]. The READ cycle gives them one cycle to settle
//   before the values are captured on the edge into DONE.
//
// Ports
//   CLK, RST               clock (rising edge), asynchronous active-high reset
//   A_* / B_*              requester fields: REQ, WE, DR, SR1, SR2, DATA in;
//                          ACK out (one-cycle pulse, RD_* valid while high)
//   RD_SR1, RD_SR2         captured read data of the last completed transaction
//   RD_OWNER               0 = last completed transaction was A's, 1 = B's
//   BUSY                   high whenever the FSM is not IDLE
//   RF_LD, RF_DR, RF_SR1,  register-file control, all registered
//   RF_SR2, RF_DR_IN
//   RF_SR1_OUT, RF_SR2_OUT register-file read data
// Parameters
//   DATA_W  data width, ADDR_W register index width,
//   WR_HOLD cycles RF_LD stays high per write (legal range 1..15)
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int WR_HOLD = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_DR,
  input  logic [ADDR_W-1:0] A_SR1,
  input  logic [ADDR_W-1:0] A_SR2,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_ACK,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_DR,
  input  logic [ADDR_W-1:0] B_SR1,
  input  logic [ADDR_W-1:0] B_SR2,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_ACK,
  output logic [DATA_W-1:0] RD_SR1,
  output logic [DATA_W-1:0] RD_SR2,
  output logic              RD_OWNER,
  output logic              BUSY,
  output logic              RF_LD,
  output logic [ADDR_W-1:0] RF_DR,
  output logic [ADDR_W-1:0] RF_SR1,
  output logic [ADDR_W-1:0] RF_SR2,
  output logic [DATA_W-1:0] RF_DR_IN,
  input  logic [DATA_W-1:0] RF_SR1_OUT,
  input  logic [DATA_W-1:0] RF_SR2_OUT
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  // Last value the write-hold counter reaches before leaving WRITE.
  localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD - 1);

  // FSM state and arbitration bookkeeping
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_gnt_q, last_gnt_d;   // 1 = B was granted last
  logic       owner_q, owner_d;         // 1 = current transaction is B's

  // Registered datapath / outputs
  logic              rf_ld_q, rf_ld_d;
  logic [ADDR_W-1:0] rf_dr_q, rf_dr_d;
  logic [ADDR_W-1:0] rf_sr1_q, rf_sr1_d;
  logic [ADDR_W-1:0] rf_sr2_q, rf_sr2_d;
  logic [DATA_W-1:0] rf_dr_in_q, rf_dr_in_d;
  logic [DATA_W-1:0] rd_sr1_q, rd_sr1_d;
  logic [DATA_W-1:0] rd_sr2_q, rd_sr2_d;
  logic              rd_owner_q, rd_owner_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;

  // Round-robin grant: a lone request always wins; on a tie the requester
  // that was not granted last wins.
  logic gnt_a, gnt_b, grant, sel_we;
  assign gnt_a  = A_REQ & (~B_REQ | last_gnt_q);
  assign gnt_b  = B_REQ & (~A_REQ | ~last_gnt_q);
  assign grant  = (state_q == IDLE) & (gnt_a | gnt_b);
  assign sel_we = gnt_b ? B_WE : A_WE;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every flop resets asynchronously, so RF_LD drops the instant RST
  // rises even in the middle of a write hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;   // pretend B went last so A wins the first tie
      owner_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: hold-by-default assignments first keep this block latch-free.
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d    = gnt_b;
          last_gnt_d = gnt_b;
          cnt_d      = '0;
          state_d    = sel_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (cnt_q == HOLD_LAST) state_d = READ;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    rf_dr_d    = rf_dr_q;
    rf_sr1_d   = rf_sr1_q;
    rf_sr2_d   = rf_sr2_q;
    rf_dr_in_d = rf_dr_in_q;
    rd_sr1_d   = rd_sr1_q;
    rd_sr2_d   = rd_sr2_q;
    rd_owner_d = rd_owner_q;

    // Fields are latched only at grant, so RF_DR/RF_DR_IN cannot move while
    // RF_LD is high and simply hold their last values across IDLE.
    if (grant) begin
      rf_dr_d    = gnt_b ? B_DR   : A_DR;
      rf_sr1_d   = gnt_b ? B_SR1  : A_SR1;
      rf_sr2_d   = gnt_b ? B_SR2  : A_SR2;
      rf_dr_in_d = gnt_b ? B_DATA : A_DATA;
    end

    // RF_LD is high exactly for the cycles spent in WRITE.
    rf_ld_d = (state_d == WRITE);

    // READ is the settle cycle; its closing edge captures the read data and
    // raises the owner's ACK, both visible during DONE.
    if (state_q == READ) begin
      rd_sr1_d   = RF_SR1_OUT;
      rd_sr2_d   = RF_SR2_OUT;
      rd_owner_d = owner_q;
    end
    a_ack_d = (state_q == READ) & ~owner_q;
    b_ack_d = (state_q == READ) &  owner_q;

    BUSY = (state_q != IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath / output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_ld_q    <= 1'b0;
      rf_dr_q    <= '0;
      rf_sr1_q   <= '0;
      rf_sr2_q   <= '0;
      rf_dr_in_q <= '0;
      rd_sr1_q   <= '0;
      rd_sr2_q   <= '0;
      rd_owner_q <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
    end else begin
      rf_ld_q    <= rf_ld_d;
      rf_dr_q    <= rf_dr_d;
      rf_sr1_q   <= rf_sr1_d;
      rf_sr2_q   <= rf_sr2_d;
      rf_dr_in_q <= rf_dr_in_d;
      rd_sr1_q   <= rd_sr1_d;
      rd_sr2_q   <= rd_sr2_d;
      rd_owner_q <= rd_owner_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
    end
  end

  assign RF_LD    = rf_ld_q;
  assign RF_DR    = rf_dr_q;
  assign RF_SR1   = rf_sr1_q;
  assign RF_SR2   = rf_sr2_q;
  assign RF_DR_IN = rf_dr_in_q;
  assign RD_SR1   = rd_sr1_q;
  assign RD_SR2   = rd_sr2_q;
  assign RD_OWNER = rd_owner_q;
  assign A_ACK    = a_ack_q;
  assign B_ACK    = b_ack_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
//   Drives regfile_arbiter with directed and randomized transactions from two
//   requesters. A behavioural register file sits on the RF_* pins. Expected
//   read data comes from a separate reference array that is updated in
//   transaction order. Latency, RF_LD hold length, write-field stability,
//   BUSY, ACK routing and round-robin order are all checked.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int WR_HOLD = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_req = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_dr = '0, a_sr1 = '0, a_sr2 = '0;
  logic [DATA_W-1:0] a_data = '0;
  logic              a_ack;
  logic              b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_dr = '0, b_sr1 = '0, b_sr2 = '0;
  logic [DATA_W-1:0] b_data = '0;
  logic              b_ack;
  logic [DATA_W-1:0] rd_sr1, rd_sr2;
  logic              rd_owner, busy;
  logic              rf_ld;
  logic [ADDR_W-1:0] rf_dr, rf_sr1, rf_sr2;
  logic [DATA_W-1:0] rf_dr_in, rf_sr1_out, rf_sr2_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference register contents; ref_known clears when a write is aborted.
  logic [DATA_W-1:0] ref_mem   [8];
  bit                ref_known [8];
  logic              model_last;   // requester served most recently (1 = B)

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_HOLD(WR_HOLD)) dut (
    .CLK(clk), .RST(rst),
    .A_REQ(a_req), .A_WE(a_we), .A_DR(a_dr), .A_SR1(a_sr1), .A_SR2(a_sr2),
    .A_DATA(a_data), .A_ACK(a_ack),
    .B_REQ(b_req), .B_WE(b_we), .B_DR(b_dr), .B_SR1(b_sr1), .B_SR2(b_sr2),
    .B_DATA(b_data), .B_ACK(b_ack),
    .RD_SR1(rd_sr1), .RD_SR2(rd_sr2), .RD_OWNER(rd_owner), .BUSY(busy),
    .RF_LD(rf_ld), .RF_DR(rf_dr), .RF_SR1(rf_sr1), .RF_SR2(rf_sr2),
    .RF_DR_IN(rf_dr_in), .RF_SR1_OUT(rf_sr1_out), .RF_SR2_OUT(rf_sr2_out)
  );

  // Behavioural register file: writes on every edge while LD=1; read ports
  // are transparent (they are only sampled while LD=0).
  logic [DATA_W-1:0] rf_mem [8] = '{default: '0};
  always @(posedge clk) if (rf_ld) rf_mem[rf_dr] <= rf_dr_in;
  assign rf_sr1_out = rf_mem[rf_sr1];
  assign rf_sr2_out = rf_mem[rf_sr2];

  // One transaction from a single requester, started while the DUT is IDLE
  // (called #1 after a rising edge).
  task automatic run_one(input logic who, input logic we,
                         input logic [2:0] dr, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [15:0] data,
                         input string tag);
    int n = 0, ld_cycles = 0, exp_lat;
    bit got = 0, fields_bad = 0, busy_bad = 0, k1, k2;
    logic [15:0] e1, e2;
    if (we) begin ref_mem[dr] = data; ref_known[dr] = 1; end
    e1 = ref_mem[s1]; k1 = ref_known[s1];
    e2 = ref_mem[s2]; k2 = ref_known[s2];
    exp_lat = we ? WR_HOLD + 2 : 2;
    if (who) begin b_we = we; b_dr = dr; b_sr1 = s1; b_sr2 = s2; b_data = data; b_req = 1; end
    else     begin a_we = we; a_dr = dr; a_sr1 = s1; a_sr2 = s2; a_data = data; a_req = 1; end
    while (!got && n < WR_HOLD + 10) begin
      @(posedge clk); #1; n++;
      if (rf_ld) begin
        ld_cycles++;
        if (rf_dr !== dr || rf_dr_in !== data) fields_bad = 1;
      end
      if (!busy) busy_bad = 1;
      if (a_ack || b_ack) got = 1;
    end
    total_cnt++;
    if (!got) $display("FAIL %s ack_timeout: no ACK after %0d cycles", tag, n);
    else begin
      pass_cnt++;
      total_cnt++;
      if (n !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", tag, n, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if ({a_ack, b_ack} !== (who ? 2'b01 : 2'b10))
        $display("FAIL %s ack_route: got a=%b b=%b expected owner %b", tag, a_ack, b_ack, who);
      else pass_cnt++;
      total_cnt++;
      if (rd_owner !== who) $display("FAIL %s rd_owner: got %b expected %b", tag, rd_owner, who);
      else pass_cnt++;
      if (k1) begin
        total_cnt++;
        if (rd_sr1 !== e1) $display("FAIL %s rd_sr1: got %h expected %h", tag, rd_sr1, e1);
        else pass_cnt++;
      end
      if (k2) begin
        total_cnt++;
        if (rd_sr2 !== e2) $display("FAIL %s rd_sr2: got %h expected %h", tag, rd_sr2, e2);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (ld_cycles !== (we ? WR_HOLD : 0))
      $display("FAIL %s ld_cycles: got %0d expected %0d", tag, ld_cycles, we ? WR_HOLD : 0);
    else pass_cnt++;
    total_cnt++;
    if (fields_bad || busy_bad)
      $display("FAIL %s stability: fields_moved=%b busy_dropped=%b expected 0/0", tag, fields_bad, busy_bad);
    else pass_cnt++;
    if (who) b_req = 0; else a_req = 0;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, a_ack, b_ack} !== 3'b000)
      $display("FAIL %s idle_gap: got busy=%b a_ack=%b b_ack=%b expected 000", tag, busy, a_ack, b_ack);
    else pass_cnt++;
    model_last = who;
  endtask

  task automatic test_reset();
    rst = 1; #1;
    total_cnt++;
    if ({a_ack, b_ack, rd_sr1, rd_sr2, rd_owner, busy, rf_ld, rf_dr, rf_sr1, rf_sr2, rf_dr_in} !== '0)
      $display("FAIL reset_async: outputs not zero (rd_sr1=%h rf_ld=%b busy=%b)", rd_sr1, rf_ld, busy);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; ref_known[i] = 1; end
    model_last = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({a_ack, b_ack, rd_sr1, rd_sr2, rd_owner, busy, rf_ld} !== '0)
      $display("FAIL reset_idle: got busy=%b rf_ld=%b rd_sr1=%h expected zeros", busy, rf_ld, rd_sr1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    int acks = 0;
    a_we = 1; a_dr = 3'd5; a_sr1 = 3'd5; a_sr2 = 3'd1; a_data = 16'h1234; a_req = 1;
    @(posedge clk); #1;
    total_cnt++;
    if (rf_ld !== 1'b1) $display("FAIL midwr_ld_up: got %b expected 1", rf_ld);
    else pass_cnt++;
    rst = 1; #1;
    total_cnt++;
    if ({rf_ld, busy, a_ack, b_ack} !== 4'b0000)
      $display("FAIL midwr_abort: got ld=%b busy=%b acks=%b%b expected 0000", rf_ld, busy, a_ack, b_ack);
    else pass_cnt++;
    a_req = 0;
    @(posedge clk); #1 rst = 0;
    ref_known[5] = 0;
    model_last = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_ack || b_ack || busy) acks++;
    end
    total_cnt++;
    if (acks !== 0) $display("FAIL midwr_no_ack: got %0d active cycles expected 0", acks);
    else pass_cnt++;
    run_one(1'b0, 1'b1, 3'd5, 3'd5, 3'd2, 16'h5A5A, "midwr_recover");
  endtask

  task automatic test_write_read();
    run_one(1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 16'hBEEF, "a_write_r3");
    run_one(1'b1, 1'b0, 3'd0, 3'd3, 3'd3, 16'h0000, "b_read_r3");
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({rd_sr1, rd_sr2, rd_owner} !== {16'hBEEF, 16'hBEEF, 1'b1})
      $display("FAIL rd_hold: got %h %h %b expected beef beef 1", rd_sr1, rd_sr2, rd_owner);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int acks = 0, cyc = 0;
    logic exp_owner;
    logic [2:0] s2;
    logic [15:0] e1, e2;
    a_we = 1; a_dr = 3'd6; a_sr1 = 3'd6; a_sr2 = 3'd1; a_data = 16'hA5A5;
    b_we = 0; b_dr = 3'd0; b_sr1 = 3'd6; b_sr2 = 3'd2; b_data = 16'h0000;
    exp_owner = ~model_last;
    a_req = 1; b_req = 1;
    while (acks < 4 && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (a_ack || b_ack) begin
        if (!exp_owner) begin ref_mem[6] = 16'hA5A5; ref_known[6] = 1; end
        s2 = exp_owner ? 3'd2 : 3'd1;
        e1 = ref_mem[6]; e2 = ref_mem[s2];
        total_cnt++;
        if ({a_ack, b_ack} !== (exp_owner ? 2'b01 : 2'b10))
          $display("FAIL rr_order%0d: got a=%b b=%b expected owner %b", acks, a_ack, b_ack, exp_owner);
        else pass_cnt++;
        total_cnt++;
        if ({rd_owner, rd_sr1, rd_sr2} !== {exp_owner, e1, e2})
          $display("FAIL rr_data%0d: got %b %h %h expected %b %h %h", acks, rd_owner, rd_sr1, rd_sr2, exp_owner, e1, e2);
        else pass_cnt++;
        exp_owner = ~exp_owner;
        acks++;
      end
    end
    total_cnt++;
    if (acks !== 4) $display("FAIL rr_timeout: got %0d acks expected 4", acks);
    else pass_cnt++;
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    model_last = ~exp_owner;
  endtask

  task automatic test_fill_and_pairs();
    for (int i = 0; i < 8; i++)
      run_one(1'b0, 1'b1, 3'(i), 3'(i), 3'(7 - i), 16'h1000 + 16'(i), "fill");
    for (int i = 0; i < 8; i++)
      run_one(1'b1, 1'b0, 3'd0, 3'(i), 3'(7 - i), 16'h0000, "pairs");
  endtask

  task automatic test_random_mix();
    for (int t = 0; t < 200; t++) begin
      run_one(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
              16'($urandom), "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_write_read();
    test_round_robin();
    test_fill_and_pairs();
    test_random_mix();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
